// File: rtl/config_pkg.sv
// Shared DDR types and the arbiter state encoding used by the memory
// front-end.
package config_pkg;

  localparam int unsigned DdrAddrWidth = 32;
  localparam int unsigned DdrDataWidth = 32;

  typedef logic [DdrAddrWidth-1:0] ddr_address_t;
  typedef logic [DdrDataWidth-1:0] ddr_data_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } arb_state_t;

endpackage

// File: rtl/ddr_arbiter.sv
// Two-client round-robin arbiter in front of a single DDR port.
// Client 0 is vector_load_store; client 1 is the matrix weight fetch unit.
module ddr_arbiter
  import config_pkg::*;
#(
  parameter bit WriteFirst = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,

  input  ddr_address_t c0_ddr_address_i,
  input  logic         c0_ddr_w_en_i,
  input  ddr_data_t    c0_ddr_w_data_i,
  output logic         c0_ddr_w_done_o,
  input  logic         c0_ddr_r_en_i,
  output ddr_data_t    c0_ddr_r_data_o,
  output logic         c0_ddr_r_valid_o,

  input  ddr_address_t c1_ddr_address_i,
  input  logic         c1_ddr_w_en_i,
  input  ddr_data_t    c1_ddr_w_data_i,
  output logic         c1_ddr_w_done_o,
  input  logic         c1_ddr_r_en_i,
  output ddr_data_t    c1_ddr_r_data_o,
  output logic         c1_ddr_r_valid_o,

  output ddr_address_t ddr_address_o,
  output logic         ddr_w_en_o,
  output ddr_data_t    ddr_w_data_o,
  output logic         ddr_r_en_o,
  input  logic         ddr_w_done_i,
  input  ddr_data_t    ddr_r_data_i,
  input  logic         ddr_r_valid_i,

  output logic         busy_o
);

  arb_state_t   state_q, state_d;
  logic         client_q, client_d;
  logic         last_q, last_d;
  ddr_address_t addr_q, addr_d;
  ddr_data_t    w_data_q, w_data_d;
  logic         w_en_q, w_en_d;
  logic         r_en_q, r_en_d;

  logic         req0, req1, pick, sel_r, sel_w, go_write;
  ddr_address_t sel_addr;
  ddr_data_t    sel_w_data;

  always_comb begin
    state_d  = state_q;
    client_d = client_q;
    last_d   = last_q;
    addr_d   = addr_q;
    w_data_d = w_data_q;
    w_en_d   = w_en_q;
    r_en_d   = r_en_q;

    req0 = c0_ddr_r_en_i | c0_ddr_w_en_i;
    req1 = c1_ddr_r_en_i | c1_ddr_w_en_i;
    // On a tie the client that was not served last wins.
    pick       = (req0 && req1) ? ~last_q : req1;
    sel_r      = pick ? c1_ddr_r_en_i    : c0_ddr_r_en_i;
    sel_w      = pick ? c1_ddr_w_en_i    : c0_ddr_w_en_i;
    sel_addr   = pick ? c1_ddr_address_i : c0_ddr_address_i;
    sel_w_data = pick ? c1_ddr_w_data_i  : c0_ddr_w_data_i;
    go_write   = sel_w && (WriteFirst || !sel_r);

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          client_d = pick;
          last_d   = pick;
          addr_d   = sel_addr;
          w_data_d = sel_w_data;
          if (go_write) begin
            state_d = WRITE;
            w_en_d  = 1'b1;
          end else begin
            state_d = READ;
            r_en_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (ddr_r_valid_i) begin
          state_d = IDLE;
          r_en_d  = 1'b0;
        end
      end
      WRITE: begin
        if (ddr_w_done_i) begin
          state_d = IDLE;
          w_en_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        w_en_d  = 1'b0;
        r_en_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      client_q <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      w_data_q <= '0;
      w_en_q   <= 1'b0;
      r_en_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      client_q <= client_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      w_data_q <= w_data_d;
      w_en_q   <= w_en_d;
      r_en_q   <= r_en_d;
    end
  end

  // Responses are steered only to the granted client and only for the active op.
  assign c0_ddr_r_valid_o = (state_q == READ)  && !client_q && ddr_r_valid_i;
  assign c1_ddr_r_valid_o = (state_q == READ)  &&  client_q && ddr_r_valid_i;
  assign c0_ddr_w_done_o  = (state_q == WRITE) && !client_q && ddr_w_done_i;
  assign c1_ddr_w_done_o  = (state_q == WRITE) &&  client_q && ddr_w_done_i;
  assign c0_ddr_r_data_o  = ddr_r_data_i;
  assign c1_ddr_r_data_o  = ddr_r_data_i;

  assign ddr_address_o = addr_q;
  assign ddr_w_data_o  = w_data_q;
  assign ddr_w_en_o    = w_en_q;
  assign ddr_r_en_o    = r_en_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter with a transaction-level reference model
// compared against the DUT on every falling edge.
module tb_ddr_arbiter;
  import config_pkg::*;

  localparam bit WriteFirst = 1'b1;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  ddr_address_t c0_ddr_address_i = '0, c1_ddr_address_i = '0;
  logic         c0_ddr_w_en_i = 1'b0, c1_ddr_w_en_i = 1'b0;
  ddr_data_t    c0_ddr_w_data_i = '0, c1_ddr_w_data_i = '0;
  logic         c0_ddr_r_en_i = 1'b0, c1_ddr_r_en_i = 1'b0;
  logic         c0_ddr_w_done_o, c1_ddr_w_done_o;
  ddr_data_t    c0_ddr_r_data_o, c1_ddr_r_data_o;
  logic         c0_ddr_r_valid_o, c1_ddr_r_valid_o;
  ddr_address_t ddr_address_o;
  logic         ddr_w_en_o, ddr_r_en_o;
  ddr_data_t    ddr_w_data_o;
  logic         ddr_w_done_i = 1'b0;
  ddr_data_t    ddr_r_data_i = '0;
  logic         ddr_r_valid_i = 1'b0;
  logic         busy_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  ddr_arbiter #(.WriteFirst(WriteFirst)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .c0_ddr_address_i (c0_ddr_address_i),
    .c0_ddr_w_en_i    (c0_ddr_w_en_i),
    .c0_ddr_w_data_i  (c0_ddr_w_data_i),
    .c0_ddr_w_done_o  (c0_ddr_w_done_o),
    .c0_ddr_r_en_i    (c0_ddr_r_en_i),
    .c0_ddr_r_data_o  (c0_ddr_r_data_o),
    .c0_ddr_r_valid_o (c0_ddr_r_valid_o),
    .c1_ddr_address_i (c1_ddr_address_i),
    .c1_ddr_w_en_i    (c1_ddr_w_en_i),
    .c1_ddr_w_data_i  (c1_ddr_w_data_i),
    .c1_ddr_w_done_o  (c1_ddr_w_done_o),
    .c1_ddr_r_en_i    (c1_ddr_r_en_i),
    .c1_ddr_r_data_o  (c1_ddr_r_data_o),
    .c1_ddr_r_valid_o (c1_ddr_r_valid_o),
    .ddr_address_o    (ddr_address_o),
    .ddr_w_en_o       (ddr_w_en_o),
    .ddr_w_data_o     (ddr_w_data_o),
    .ddr_r_en_o       (ddr_r_en_o),
    .ddr_w_done_i     (ddr_w_done_i),
    .ddr_r_data_i     (ddr_r_data_i),
    .ddr_r_valid_i    (ddr_r_valid_i),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_cnt++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    else
      pass_cnt++;
  endtask

  // Reference model: one outstanding transaction (or none) plus the identity
  // of the client served most recently.
  typedef struct packed {
    logic         take;
    logic         client;
    logic         write;
    ddr_address_t addr;
    ddr_data_t    wdata;
  } grant_t;

  bit           m_ready = 0, m_active = 0, m_client = 0, m_write = 0, m_last = 1;
  ddr_address_t m_addr = '0;
  ddr_data_t    m_wdata = '0;
  grant_t       m_next;

  function automatic grant_t decide(input logic r0, w0, r1, w1, input logic last,
                                    input ddr_address_t a0, a1,
                                    input ddr_data_t d0, d1);
    grant_t g;
    logic   rd, wr;
    g = '0;
    if ((r0 | w0) && (r1 | w1)) begin
      g.take = 1'b1;
      g.client = (last == 1'b0);
    end else if (r0 | w0) begin
      g.take = 1'b1;
      g.client = 1'b0;
    end else if (r1 | w1) begin
      g.take = 1'b1;
      g.client = 1'b1;
    end
    rd = g.client ? r1 : r0;
    wr = g.client ? w1 : w0;
    g.write = (rd && wr) ? WriteFirst : wr;
    g.addr  = g.client ? a1 : a0;
    g.wdata = g.client ? d1 : d0;
    return g;
  endfunction

  always_comb
    m_next = decide(c0_ddr_r_en_i, c0_ddr_w_en_i, c1_ddr_r_en_i, c1_ddr_w_en_i, m_last,
                    c0_ddr_address_i, c1_ddr_address_i, c0_ddr_w_data_i, c1_ddr_w_data_i);

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      m_ready  <= 1;
      m_active <= 0;
      m_last   <= 1;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else if (m_active) begin
      if ((m_write && ddr_w_done_i) || (!m_write && ddr_r_valid_i))
        m_active <= 0;
    end else if (m_next.take) begin
      m_active <= 1;
      m_client <= m_next.client;
      m_write  <= m_next.write;
      m_last   <= m_next.client;
      m_addr   <= m_next.addr;
      m_wdata  <= m_next.wdata;
    end
  end

  always @(negedge clk_i) begin
    if (m_ready) begin
      checkOutput("ddr_r_en", ddr_r_en_o, m_active && !m_write);
      checkOutput("ddr_w_en", ddr_w_en_o, m_active && m_write);
      checkOutput("busy", busy_o, m_active);
      checkOutput("c0_r_valid", c0_ddr_r_valid_o, m_active && !m_write && !m_client && ddr_r_valid_i);
      checkOutput("c1_r_valid", c1_ddr_r_valid_o, m_active && !m_write && m_client && ddr_r_valid_i);
      checkOutput("c0_w_done", c0_ddr_w_done_o, m_active && m_write && !m_client && ddr_w_done_i);
      checkOutput("c1_w_done", c1_ddr_w_done_o, m_active && m_write && m_client && ddr_w_done_i);
      if (m_active) checkOutput("ddr_address", ddr_address_o, m_addr);
      if (m_active && m_write) checkOutput("ddr_w_data", ddr_w_data_o, m_wdata);
      if (c0_ddr_r_valid_o) checkOutput("c0_r_data", c0_ddr_r_data_o, ddr_r_data_i);
      if (c1_ddr_r_valid_o) checkOutput("c1_r_data", c1_ddr_r_data_o, ddr_r_data_i);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic c0r, c0w, c1r, c1w,
                               input ddr_address_t a0, a1, input ddr_data_t d0, d1);
    c0_ddr_r_en_i = c0r;  c0_ddr_w_en_i = c0w;
    c1_ddr_r_en_i = c1r;  c1_ddr_w_en_i = c1w;
    c0_ddr_address_i = a0; c1_ddr_address_i = a1;
    c0_ddr_w_data_i = d0;  c1_ddr_w_data_i = d1;
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    applyStimulus(0, 0, 0, 0, '0, '0, '0, '0);
    ddr_r_valid_i = 1'b0;
    ddr_w_done_i  = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_r_en", ddr_r_en_o, 0);
    checkOutput("reset_w_en", ddr_w_en_o, 0);
    checkOutput("reset_addr", ddr_address_o, 0);
    checkOutput("reset_wdata", ddr_w_data_o, 0);
  endtask

  task automatic waitGrant(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      ok = ddr_r_en_o | ddr_w_en_o;
    end
    if (!ok) checkOutput("grant_timeout", 0, 1);
  endtask

  // Respond to the active transaction, then drop the served client's request.
  task automatic finishTxn(input ddr_data_t rd, output logic served);
    logic was_write;
    int   pulses;
    was_write = ddr_w_en_o;
    if (was_write) ddr_w_done_i = 1'b1;
    else begin
      ddr_r_valid_i = 1'b1;
      ddr_r_data_i  = rd;
    end
    #1;
    pulses = int'(c0_ddr_r_valid_o) + int'(c1_ddr_r_valid_o) +
             int'(c0_ddr_w_done_o) + int'(c1_ddr_w_done_o);
    checkOutput("one_pulse", pulses, 1);
    served = c1_ddr_r_valid_o | c1_ddr_w_done_o;
    tick();
    ddr_w_done_i  = 1'b0;
    ddr_r_valid_i = 1'b0;
    if (was_write) begin
      if (served) c1_ddr_w_en_i = 1'b0; else c0_ddr_w_en_i = 1'b0;
    end else begin
      if (served) c1_ddr_r_en_i = 1'b0; else c0_ddr_r_en_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic         ok, served, dropped_valid, dropped;
    ddr_address_t seen [6];
    ddr_address_t want [6];
    want = '{32'h100, 32'h200, 32'h100, 32'h200, 32'h100, 32'h200};
    dropped_valid = 1'b0;
    dropped = 1'b0;

    // Single read from client 0.
    doReset();
    applyStimulus(1, 0, 0, 0, 32'h40, '0, '0, '0);
    checkOutput("read_latency", ddr_r_en_o, 0);
    tick();
    checkOutput("read_en", ddr_r_en_o, 1);
    checkOutput("read_addr", ddr_address_o, 32'h40);
    ddr_r_valid_i = 1'b1;
    ddr_r_data_i  = 32'hDEAD;
    #1;
    checkOutput("read_c0_valid", c0_ddr_r_valid_o, 1);
    checkOutput("read_c0_data", c0_ddr_r_data_o, 32'hDEAD);
    checkOutput("read_c1_valid", c1_ddr_r_valid_o, 0);
    tick();
    ddr_r_valid_i = 1'b0;
    c0_ddr_r_en_i = 1'b0;
    checkOutput("read_en_drop", ddr_r_en_o, 0);
    checkOutput("read_busy_drop", busy_o, 0);
    tick();

    // Write tie straight after reset: client 0 first, idle gap, then client 1.
    doReset();
    applyStimulus(0, 1, 0, 1, 32'h10, 32'h20, 32'hAAAA, 32'hBBBB);
    tick();
    checkOutput("tie_first_addr", ddr_address_o, 32'h10);
    checkOutput("tie_first_wdata", ddr_w_data_o, 32'hAAAA);
    ddr_w_done_i = 1'b1;
    #1;
    checkOutput("tie_c0_done", c0_ddr_w_done_o, 1);
    checkOutput("tie_c1_done", c1_ddr_w_done_o, 0);
    tick();
    ddr_w_done_i = 1'b0;
    c0_ddr_w_en_i = 1'b0;
    checkOutput("tie_gap_w_en", ddr_w_en_o, 0);
    tick();
    checkOutput("tie_second_w_en", ddr_w_en_o, 1);
    checkOutput("tie_second_addr", ddr_address_o, 32'h20);
    checkOutput("tie_second_wdata", ddr_w_data_o, 32'hBBBB);
    finishTxn('0, served);
    checkOutput("tie_second_client", served, 1);

    // Both clients reading back to back: grants must alternate.
    applyStimulus(1, 0, 1, 0, 32'h100, 32'h200, '0, '0);
    for (int n = 0; n < 6; n++) begin
      waitGrant(ok);
      if (dropped_valid) begin
        if (dropped) c1_ddr_r_en_i = 1'b1; else c0_ddr_r_en_i = 1'b1;
      end
      seen[n] = ddr_address_o;
      finishTxn(ddr_data_t'(n), served);
      dropped = served;
      dropped_valid = 1'b1;
    end
    c0_ddr_r_en_i = 1'b0;
    c1_ddr_r_en_i = 1'b0;
    for (int n = 0; n < 6; n++) checkOutput($sformatf("fair_grant%0d", n), seen[n], want[n]);
    tick();

    // Client 1 asks for read and write together: write goes first.
    applyStimulus(0, 0, 1, 1, '0, 32'h300, '0, 32'hC0DE);
    waitGrant(ok);
    checkOutput("combo_first_is_write", ddr_w_en_o, 1);
    checkOutput("combo_addr", ddr_address_o, 32'h300);
    checkOutput("combo_wdata", ddr_w_data_o, 32'hC0DE);
    finishTxn('0, served);
    checkOutput("combo_write_client", served, 1);
    waitGrant(ok);
    checkOutput("combo_then_read", ddr_r_en_o, 1);
    finishTxn(32'h5A5A, served);
    checkOutput("combo_read_client", served, 1);
    tick();

    // Stray responses in IDLE and during a write.
    ddr_r_valid_i = 1'b1;
    ddr_w_done_i  = 1'b1;
    #1;
    checkOutput("stray_idle_pulses",
                {c0_ddr_r_valid_o, c1_ddr_r_valid_o, c0_ddr_w_done_o, c1_ddr_w_done_o}, 0);
    tick();
    ddr_r_valid_i = 1'b0;
    ddr_w_done_i  = 1'b0;
    checkOutput("stray_idle_busy", busy_o, 0);
    applyStimulus(0, 1, 0, 0, 32'h50, '0, 32'h1234, '0);
    waitGrant(ok);
    ddr_r_valid_i = 1'b1;
    #1;
    checkOutput("stray_write_c0_valid", c0_ddr_r_valid_o, 0);
    tick();
    ddr_r_valid_i = 1'b0;
    checkOutput("stray_write_still_w_en", ddr_w_en_o, 1);
    checkOutput("stray_write_still_busy", busy_o, 1);
    finishTxn('0, served);
    tick();

    // Reset in the middle of a read; the late response must be dropped.
    applyStimulus(1, 0, 0, 0, 32'h60, '0, '0, '0);
    waitGrant(ok);
    rst_ni = 1'b0;
    c0_ddr_r_en_i = 1'b0;
    tick();
    checkOutput("midreset_r_en", ddr_r_en_o, 0);
    checkOutput("midreset_busy", busy_o, 0);
    rst_ni = 1'b1;
    ddr_r_valid_i = 1'b1;
    ddr_r_data_i  = 32'hBEEF;
    #1;
    checkOutput("midreset_late_valid", c0_ddr_r_valid_o, 0);
    tick();
    ddr_r_valid_i = 1'b0;
    checkOutput("midreset_idle", busy_o, 0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ddr_arbiter.md
DDR_ARBITER -- requirements
Module: ddr_arbiter

Interface
REQ-001 SHALL have parameter WriteFirst, default 1: when a client asserts read and write together, 1 grants the write first and 0 grants the read first.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have ports c0_ddr_address_i / c1_ddr_address_i, input, ddr_address_t: per-client address, held stable while its enable is high.
REQ-005 SHALL have ports c0_ddr_w_en_i / c1_ddr_w_en_i, input, 1 bit: per-client level write request.
REQ-006 SHALL have ports c0_ddr_w_data_i / c1_ddr_w_data_i, input, ddr_data_t: per-client write data.
REQ-007 SHALL have ports c0_ddr_w_done_o / c1_ddr_w_done_o, output, 1 bit: one-cycle write completion to the granted client.
REQ-008 SHALL have ports c0_ddr_r_en_i / c1_ddr_r_en_i, input, 1 bit: per-client level read request.
REQ-009 SHALL have ports c0_ddr_r_data_o / c1_ddr_r_data_o and c0_ddr_r_valid_o / c1_ddr_r_valid_o, output, ddr_data_t and 1 bit: read return to the granted client.
REQ-010 SHALL have ports ddr_address_o, ddr_w_en_o, ddr_w_data_o and ddr_r_en_o, output, ddr_address_t / 1 / ddr_data_t / 1: the downstream request port; all four are registered.
REQ-011 SHALL have ports ddr_w_done_i, ddr_r_data_i and ddr_r_valid_i, input, 1 / ddr_data_t / 1: the downstream response port.
REQ-012 SHALL have port busy_o, output, 1 bit: high while any transaction is granted.
REQ-013 SHALL define client 0 as vector_load_store and client 1 as the matrix weight fetch unit.

Function
REQ-014 SHALL implement a 3-state FSM with states IDLE, READ and WRITE.
- IDLE -> WRITE or READ on any pending request.
- READ -> IDLE on the cycle ddr_r_valid_i is high.
- WRITE -> IDLE on the cycle ddr_w_done_i is high.
REQ-015 SHALL, in IDLE, sample requests; the grant, granted-client index, operation, address and write data are registered at the clock edge.
REQ-016 SHALL drive the downstream enable from the cycle after the request was sampled, i.e. one cycle of request latency.
REQ-017 SHALL arbitrate round-robin by the client, not by the operation.
- When both clients request, grant the client not served last.
- The last-served pointer updates on every grant.
- The pointer resets to "client 1 last", so client 0 wins the first tie.
REQ-018 SHALL resolve a client asserting r_en and w_en together per WriteFirst; the other operation stays pending.
REQ-019 SHALL hold ddr_address_o, ddr_w_data_o and the enable constant for the whole transaction, ignoring input changes.
REQ-020 SHALL route ddr_r_valid_i, ddr_r_data_i and ddr_w_done_i combinationally, in the same cycle, to the granted client only.
- The non-granted client's done and valid stay 0.
- r_data outputs may mirror ddr_r_data_i.
REQ-021 SHALL ignore ddr_r_valid_i in WRITE, ddr_w_done_i in READ, and both in IDLE; no client pulse is generated.
REQ-022 SHALL deassert the downstream enable on the cycle after a done/valid, guaranteeing at least one idle cycle between transactions.
REQ-023 SHALL, when a new request is pending in that idle cycle, start it with enable high again on the next cycle.
REQ-024 SHALL rely on clients dropping their enable on the cycle after their done/valid; the arbiter does not filter stale requests.
REQ-025 SHALL drive busy_o as (state != IDLE).

Reset
REQ-026 SHALL, on rst_ni low at a clock edge, set: state IDLE, all downstream enables 0, address and write data 0, pointer "client 1 last", busy_o 0.
REQ-027 SHALL abandon any in-flight transaction on reset without notifying its client; a response arriving after reset is ignored.

Structure
REQ-028 SHALL take ddr_address_t and ddr_data_t from config_pkg.
REQ-029 SHALL add arb_state_t (IDLE/READ/WRITE) to config_pkg.
REQ-030 SHALL be implemented as a single module; it has no sub-module.

Verification
REQ-031 SHALL cover a single read: c0 r_en with address 0x40 -> ddr_r_en_o high one cycle later with ddr_address_o 0x40; ddr_r_valid_i with data 0xDEAD -> c0_ddr_r_valid_o pulses with 0xDEAD the same cycle, c1 stays silent.
REQ-032 SHALL cover a tie after reset: c0 and c1 write in the same cycle -> c0 is served first; after c0 w_done, one idle cycle, then c1 is served.
REQ-033 SHALL cover fairness: both clients read continuously for 6 transactions -> the grants alternate 0,1,0,1,0,1.
REQ-034 SHALL cover a combined request: c1 with r_en and w_en, WriteFirst=1 -> write granted first, read granted after w_done.
REQ-035 SHALL cover a stray response: ddr_r_valid_i high during WRITE or IDLE -> no client valid pulse, state unchanged.
REQ-036 SHALL cover reset mid-transaction: rst_ni low during READ -> next cycle all ddr enables 0, busy_o 0; a later ddr_r_valid_i produces no client pulse.
